desc_queue_manager_v2: RTL and testbench

- Per-application descriptor queue manager with runtime-configurable per-queue admission limits.
- Accepts RX packet descriptors tagged with an app/queue id and stores them in a shared, partitioned descriptor RAM (one FIFO region per queue).
- Issues one outstanding scheduling handle {qid, prio} per non-empty queue to the downstream PIFO, using round-robin arbitration.
- Serves dequeue requests by qid. Descriptors that exceed a queue's limit are dropped, and their cells are returned to the free-memory manager.

---
 rtl/desc_queue_manager_v2.sv | 206 ++++++++++++++++++++
 tb/tb_desc_queue_manager_v2.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/desc_queue_manager_v2.sv
// Per-queue descriptor FIFOs in one partitioned RAM, with admission limits, round-robin
// scheduling handles to a downstream PIFO, qid-addressed dequeue and drop/free reporting.
module desc_queue_manager_v2 #(
   parameter int NUM_QUEUES    = 16,
   parameter int QID_WIDTH     = 4,
   parameter int DESC_WIDTH    = 64,
   parameter int QUEUE_DEPTH   = 64,
   parameter int CNT_WIDTH     = 7,
   parameter int PRIO_OF       = 48,
   parameter int PRIO_WIDTH    = 8,
   parameter int CELL_ID_OF    = 0,
   parameter int CELL_ID_WIDTH = 16,
   parameter int CELL_SIZE     = 2048,
   parameter int ADDR_WIDTH    = 32,
   parameter int RESET_LIMIT   = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DESC_WIDTH-1:0] s_desc,
   input  logic [QID_WIDTH-1:0]  s_desc_qid,
   input  logic                  s_desc_valid,
   output logic                  s_desc_ready,
   output logic [QID_WIDTH-1:0]  m_handle_qid,
   output logic [PRIO_WIDTH-1:0] m_handle_prio,
   output logic                  m_handle_valid,
   input  logic                  m_handle_ready,
   input  logic                  deq_req,
   input  logic [QID_WIDTH-1:0]  deq_qid,
   output logic [DESC_WIDTH-1:0] m_deq_desc,
   output logic                  m_deq_valid,
   output logic                  m_deq_empty,
   output logic [QID_WIDTH-1:0]  m_deq_empty_qid,
   output logic                  free_req,
   output logic [ADDR_WIDTH-1:0] free_addr,
   output logic [15:0]           free_size,
   input  logic                  free_ready,
   input  logic                  cfg_wr,
   input  logic [QID_WIDTH-1:0]  cfg_qid,
   input  logic [CNT_WIDTH-1:0]  cfg_limit,
   input  logic [QID_WIDTH-1:0]  stat_qid,
   output logic [CNT_WIDTH-1:0]  stat_occupancy,
   output logic [31:0]           drop_count
);
   localparam int PTR_W      = $clog2(QUEUE_DEPTH);
   localparam int CELL_SHIFT = $clog2(CELL_SIZE);

   logic [DESC_WIDTH-1:0] mem [NUM_QUEUES*QUEUE_DEPTH];

   logic [CNT_WIDTH-1:0]  occ_q [NUM_QUEUES], occ_d [NUM_QUEUES];
   logic [CNT_WIDTH-1:0]  limit_q [NUM_QUEUES], limit_d [NUM_QUEUES];
   logic [PTR_W-1:0]      wr_ptr_q [NUM_QUEUES], wr_ptr_d [NUM_QUEUES];
   logic [PTR_W-1:0]      rd_ptr_q [NUM_QUEUES], rd_ptr_d [NUM_QUEUES];
   logic [NUM_QUEUES-1:0] outst_q, outst_d, elig;
   logic [QID_WIDTH-1:0]  rr_q, rr_d, pick;
   logic                  found;
   logic                  hv_q, hv_d;
   logic [QID_WIDTH-1:0]  hqid_q, hqid_d;
   logic [PRIO_WIDTH-1:0] hprio_q, hprio_d;
   logic                  dv_q, dv_d, de_q, de_d;
   logic [DESC_WIDTH-1:0] ddesc_q, ddesc_d, head_desc;
   logic [QID_WIDTH-1:0]  deqid_q, deqid_d;
   logic                  fr_q, fr_d;
   logic [ADDR_WIDTH-1:0] fa_q, fa_d;
   logic [31:0]           drop_q, drop_d;
   logic [CNT_WIDTH-1:0]  stat_q, stat_d, cfg_lim_c;
   logic                  enq_fire, enq_ok, drop, deq_ok, hs, arb_en;

   assign enq_fire  = s_desc_valid && !fr_q;
   assign enq_ok    = enq_fire && (occ_q[s_desc_qid] < limit_q[s_desc_qid]);
   assign drop      = enq_fire && !enq_ok;
   assign deq_ok    = deq_req && (occ_q[deq_qid] != '0);
   assign hs        = hv_q && m_handle_ready;
   assign arb_en    = !hv_q || m_handle_ready;
   assign cfg_lim_c = (cfg_limit > CNT_WIDTH'(QUEUE_DEPTH)) ? CNT_WIDTH'(QUEUE_DEPTH) : cfg_limit;
   assign head_desc = mem[{pick, rd_ptr_q[pick]}];

   always_comb begin
      outst_d = outst_q;
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
         occ_d[i]    = occ_q[i];
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         limit_d[i]  = limit_q[i];
         elig[i]     = (occ_q[i] != '0) && !outst_q[i] && !(hv_q && hqid_q == QID_WIDTH'(i));
         if (enq_ok && s_desc_qid == QID_WIDTH'(i)) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            occ_d[i]    = occ_d[i] + CNT_WIDTH'(1);
         end
         if (deq_ok && deq_qid == QID_WIDTH'(i)) begin
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            occ_d[i]    = occ_d[i] - CNT_WIDTH'(1);
         end
         if (cfg_wr && cfg_qid == QID_WIDTH'(i)) limit_d[i] = cfg_lim_c;
      end
      // a handshake in the same cycle as a dequeue of that qid leaves it in flight
      if (deq_req) outst_d[deq_qid] = 1'b0;
      if (hs) outst_d[hqid_q] = 1'b1;
   end

   // rr_q holds the first queue to consider, i.e. one past the last grant
   always_comb begin
      int unsigned j;
      found = 1'b0;
      pick  = '0;
      for (int unsigned k = 0; k < NUM_QUEUES; k++) begin
         j = (32'(rr_q) + k) % NUM_QUEUES;
         if (!found && elig[j]) begin
            found = 1'b1;
            pick  = QID_WIDTH'(j);
         end
      end
   end

   always_comb begin
      hv_d    = hv_q;
      hqid_d  = hqid_q;
      hprio_d = hprio_q;
      rr_d    = rr_q;
      if (arb_en) begin
         hv_d = found;
         if (found) begin
            hqid_d  = pick;
            hprio_d = head_desc[PRIO_OF +: PRIO_WIDTH];
            rr_d    = (pick == QID_WIDTH'(NUM_QUEUES - 1)) ? '0 : pick + QID_WIDTH'(1);
         end
      end
   end

   always_comb begin
      dv_d    = deq_ok;
      de_d    = deq_req && !deq_ok;
      ddesc_d = deq_ok ? mem[{deq_qid, rd_ptr_q[deq_qid]}] : ddesc_q;
      deqid_d = (deq_req && !deq_ok) ? deq_qid : deqid_q;
      stat_d  = occ_q[stat_qid];
      fr_d    = fr_q;
      fa_d    = fa_q;
      drop_d  = drop_q;
      if (drop) begin
         fr_d = 1'b1;
         fa_d = ADDR_WIDTH'(s_desc[CELL_ID_OF +: CELL_ID_WIDTH]) << CELL_SHIFT;
         if (drop_q != '1) drop_d = drop_q + 32'd1;
      end else if (fr_q && free_ready) begin
         fr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && enq_ok) mem[{s_desc_qid, wr_ptr_q[s_desc_qid]}] <= s_desc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
            occ_q[i]    <= '0;
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            limit_q[i]  <= CNT_WIDTH'(RESET_LIMIT);
         end
         outst_q <= '0;
         rr_q    <= '0;
         hv_q    <= 1'b0;
         hqid_q  <= '0;
         hprio_q <= '0;
         dv_q    <= 1'b0;
         de_q    <= 1'b0;
         ddesc_q <= '0;
         deqid_q <= '0;
         fr_q    <= 1'b0;
         fa_q    <= '0;
         drop_q  <= '0;
         stat_q  <= '0;
      end else begin
         occ_q    <= occ_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         limit_q  <= limit_d;
         outst_q  <= outst_d;
         rr_q     <= rr_d;
         hv_q     <= hv_d;
         hqid_q   <= hqid_d;
         hprio_q  <= hprio_d;
         dv_q     <= dv_d;
         de_q     <= de_d;
         ddesc_q  <= ddesc_d;
         deqid_q  <= deqid_d;
         fr_q     <= fr_d;
         fa_q     <= fa_d;
         drop_q   <= drop_d;
         stat_q   <= stat_d;
      end
   end

   assign s_desc_ready    = !fr_q;
   assign m_handle_valid  = hv_q;
   assign m_handle_qid    = hqid_q;
   assign m_handle_prio   = hprio_q;
   assign m_deq_valid     = dv_q;
   assign m_deq_desc      = ddesc_q;
   assign m_deq_empty     = de_q;
   assign m_deq_empty_qid = deqid_q;
   assign free_req        = fr_q;
   assign free_addr       = fa_q;
   assign free_size       = 16'd1;
   assign drop_count      = drop_q;
   assign stat_occupancy  = stat_q;
endmodule

// File: tb/tb_desc_queue_manager_v2.sv
// Bench for desc_queue_manager_v2: directed scenarios plus random traffic, all checked
// against a queue-based reference model advanced once per clock.
module tb_desc_queue_manager_v2;
   localparam int NQ = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] s_desc;
   logic [3:0]  s_desc_qid;
   logic        s_desc_valid, s_desc_ready;
   logic [3:0]  m_handle_qid;
   logic [7:0]  m_handle_prio;
   logic        m_handle_valid, m_handle_ready;
   logic        deq_req;
   logic [3:0]  deq_qid;
   logic [63:0] m_deq_desc;
   logic        m_deq_valid, m_deq_empty;
   logic [3:0]  m_deq_empty_qid;
   logic        free_req, free_ready;
   logic [31:0] free_addr;
   logic [15:0] free_size;
   logic        cfg_wr;
   logic [3:0]  cfg_qid;
   logic [6:0]  cfg_limit;
   logic [3:0]  stat_qid;
   logic [6:0]  stat_occupancy;
   logic [31:0] drop_count;

   desc_queue_manager_v2 dut (
      .clk(clk), .rst(rst),
      .s_desc(s_desc), .s_desc_qid(s_desc_qid), .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
      .m_handle_qid(m_handle_qid), .m_handle_prio(m_handle_prio), .m_handle_valid(m_handle_valid),
      .m_handle_ready(m_handle_ready),
      .deq_req(deq_req), .deq_qid(deq_qid), .m_deq_desc(m_deq_desc), .m_deq_valid(m_deq_valid),
      .m_deq_empty(m_deq_empty), .m_deq_empty_qid(m_deq_empty_qid),
      .free_req(free_req), .free_addr(free_addr), .free_size(free_size), .free_ready(free_ready),
      .cfg_wr(cfg_wr), .cfg_qid(cfg_qid), .cfg_limit(cfg_limit),
      .stat_qid(stat_qid), .stat_occupancy(stat_occupancy), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // reference model state
   logic [63:0] mq [NQ][$];
   int          lim [NQ];
   bit          outst [NQ];
   bit          m_hv, m_dv, m_de, m_fr;
   int          m_hqid, m_rr, m_deqid, m_stat;
   logic [7:0]  m_hprio;
   logic [63:0] m_ddesc;
   logic [31:0] m_fa;
   longint      m_dc;

   task automatic model_reset();
      for (int i = 0; i < NQ; i++) begin
         mq[i].delete();
         lim[i] = 64;
         outst[i] = 0;
      end
      m_hv = 0; m_dv = 0; m_de = 0; m_fr = 0;
      m_hqid = 0; m_rr = 0; m_deqid = 0; m_stat = 0;
      m_hprio = '0; m_ddesc = '0; m_fa = '0; m_dc = 0;
   endtask

   // advance the model with the inputs currently applied, then clock the DUT
   task automatic tick();
      if (rst) begin
         model_reset();
      end else begin
         int          eq = int'(s_desc_qid);
         int          dq = int'(deq_qid);
         bit          fire = s_desc_valid && !m_fr;
         bit          admit = fire && (mq[eq].size() < lim[eq]);
         bit          dq_ok = deq_req && (mq[dq].size() > 0);
         int          st = mq[int'(stat_qid)].size();
         bit          n_hv = m_hv;
         int          n_q = m_hqid;
         int          n_rr = m_rr;
         logic [7:0]  n_p = m_hprio;
         logic [63:0] tmp;
         if (!m_hv || m_handle_ready) begin
            n_hv = 0;
            for (int k = 0; k < NQ; k++) begin
               int j = (m_rr + k) % NQ;
               if (!n_hv && mq[j].size() > 0 && !outst[j] && !(m_hv && m_hqid == j)) begin
                  n_hv = 1; n_q = j; tmp = mq[j][0]; n_p = tmp[55:48]; n_rr = (j + 1) % NQ;
               end
            end
         end
         if (deq_req) outst[dq] = 0;
         if (m_hv && m_handle_ready) outst[m_hqid] = 1;
         m_hv = n_hv; m_hqid = n_q; m_hprio = n_p; m_rr = n_rr;
         m_dv = dq_ok;
         m_de = deq_req && !dq_ok;
         if (dq_ok) m_ddesc = mq[dq].pop_front();
         if (m_de) m_deqid = dq;
         if (admit) begin
            mq[eq].push_back(s_desc);
         end else if (fire) begin
            tmp = s_desc;
            m_fr = 1;
            m_fa = 32'(tmp[15:0]) * 32'd2048;
            if (m_dc < 64'hFFFF_FFFF) m_dc++;
         end else if (m_fr && free_ready) begin
            m_fr = 0;
         end
         if (cfg_wr) lim[int'(cfg_qid)] = (int'(cfg_limit) > 64) ? 64 : int'(cfg_limit);
         m_stat = st;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_desc_valid = 0; deq_req = 0; cfg_wr = 0;
   endtask

   function automatic logic [63:0] rdesc(input logic [7:0] prio);
      logic [63:0] d;
      d = {$urandom, $urandom};
      d[55:48] = prio;
      return d;
   endfunction

   task automatic test_reset();
      rst = 1; idle(); m_handle_ready = 0; free_ready = 0; stat_qid = 0;
      s_desc = '0; s_desc_qid = 0; deq_qid = 0; cfg_qid = 0; cfg_limit = 0;
      tick(); tick();
      rst = 0;
      checks++; if (m_handle_valid !== 1'b0) begin fails++; $display("FAIL reset_hv: got %0b exp 0", m_handle_valid); end
      checks++; if (m_deq_valid !== 1'b0) begin fails++; $display("FAIL reset_dv: got %0b exp 0", m_deq_valid); end
      checks++; if (m_deq_empty !== 1'b0) begin fails++; $display("FAIL reset_de: got %0b exp 0", m_deq_empty); end
      checks++; if (free_req !== 1'b0) begin fails++; $display("FAIL reset_free: got %0b exp 0", free_req); end
      checks++; if (drop_count !== 32'd0) begin fails++; $display("FAIL reset_drops: got %0d exp 0", drop_count); end
      checks++; if (stat_occupancy !== 7'd0) begin fails++; $display("FAIL reset_stat: got %0d exp 0", stat_occupancy); end
      checks++; if (s_desc_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b exp 1", s_desc_ready); end
      checks++; if (free_size !== 16'd1) begin fails++; $display("FAIL free_size: got %0d exp 1", free_size); end
   endtask

   task automatic test_enqueue_handle();
      logic [63:0] d [3];
      d[0] = rdesc(8'd5); d[1] = rdesc(8'd9); d[2] = rdesc(8'd1);
      for (int i = 0; i < 3; i++) begin
         s_desc_valid = 1; s_desc_qid = 4'd2; s_desc = d[i];
         tick();
      end
      idle(); tick();
      checks++; if (m_handle_valid !== 1'b1 || m_handle_qid !== 4'd2 || m_handle_prio !== 8'd5) begin
         fails++; $display("FAIL first_handle: got v=%0b q=%0d p=%0d exp v=1 q=2 p=5", m_handle_valid, m_handle_qid, m_handle_prio); end
      m_handle_ready = 1; tick(); m_handle_ready = 0;
      checks++; if (m_handle_valid !== m_hv) begin fails++; $display("FAIL handle_after_hs: got %0b exp %0b", m_handle_valid, m_hv); end
      deq_req = 1; deq_qid = 4'd2; tick(); deq_req = 0;
      checks++; if (m_deq_valid !== 1'b1 || m_deq_desc !== d[0]) begin
         fails++; $display("FAIL deq_head: got v=%0b d=%h exp v=1 d=%h", m_deq_valid, m_deq_desc, d[0]); end
      checks++; if (m_deq_empty !== 1'b0) begin fails++; $display("FAIL deq_head_empty: got %0b exp 0", m_deq_empty); end
      stat_qid = 4'd2; tick();
      checks++; if (stat_occupancy !== 7'd2) begin fails++; $display("FAIL stat_q2: got %0d exp 2", stat_occupancy); end
      checks++; if (m_handle_valid !== 1'b1 || m_handle_prio !== 8'd9) begin
         fails++; $display("FAIL reissue: got v=%0b p=%0d exp v=1 p=9", m_handle_valid, m_handle_prio); end
   endtask

   task automatic test_drop();
      logic [63:0] d;
      logic [31:0] exp_addr;
      cfg_wr = 1; cfg_qid = 4'd3; cfg_limit = 7'd2; tick(); cfg_wr = 0;
      free_ready = 0;
      for (int i = 0; i < 3; i++) begin
         d = rdesc(8'($urandom));
         s_desc_valid = 1; s_desc_qid = 4'd3; s_desc = d;
         checks++; if (s_desc_ready !== 1'b1) begin fails++; $display("FAIL drop_ready_pre%0d: got %0b exp 1", i, s_desc_ready); end
         tick();
      end
      exp_addr = 32'(d[15:0]) * 32'd2048;
      s_desc = rdesc(8'd3); s_desc_qid = 4'd10;
      for (int c = 0; c < 4; c++) begin
         checks++; if (free_req !== 1'b1 || free_addr !== exp_addr) begin
            fails++; $display("FAIL free_hold%0d: got req=%0b addr=%h exp req=1 addr=%h", c, free_req, free_addr, exp_addr); end
         checks++; if (s_desc_ready !== 1'b0) begin fails++; $display("FAIL ready_low%0d: got %0b exp 0", c, s_desc_ready); end
         checks++; if (drop_count !== 32'd1) begin fails++; $display("FAIL drop_cnt1: got %0d exp 1", drop_count); end
         if (c < 3) tick();
      end
      s_desc_valid = 0; free_ready = 1; tick(); free_ready = 0;
      checks++; if (free_req !== 1'b0 || s_desc_ready !== 1'b1) begin
         fails++; $display("FAIL free_clear: got req=%0b rdy=%0b exp req=0 rdy=1", free_req, s_desc_ready); end
      stat_qid = 4'd10; tick();
      checks++; if (stat_occupancy !== 7'd0) begin fails++; $display("FAIL blocked_enq: got %0d exp 0", stat_occupancy); end
      cfg_wr = 1; cfg_qid = 4'd9; cfg_limit = 7'd0; tick(); cfg_wr = 0;
      s_desc_valid = 1; s_desc_qid = 4'd9; s_desc = rdesc(8'd7); tick(); idle();
      checks++; if (free_req !== 1'b1 || drop_count !== 32'd2) begin
         fails++; $display("FAIL limit0_drop: got req=%0b drops=%0d exp req=1 drops=2", free_req, drop_count); end
      free_ready = 1; tick();
      checks++; if (free_req !== 1'b0) begin fails++; $display("FAIL limit0_clear: got %0b exp 0", free_req); end
   endtask

   task automatic test_round_robin();
      int grants [$];
      int seq [6] = '{0, 5, 7, 0, 5, 7};
      rst = 1; idle(); tick(); rst = 0;
      m_handle_ready = 1;
      for (int i = 0; i < 16; i++) begin
         if (i < 6) begin s_desc_valid = 1; s_desc_qid = 4'(seq[i]); s_desc = rdesc(8'(i)); end
         else idle();
         tick();
         checks++; if (m_handle_valid !== m_hv || (m_hv && m_handle_qid !== 4'(m_hqid))) begin
            fails++; $display("FAIL rr_cycle%0d: got v=%0b q=%0d exp v=%0b q=%0d", i, m_handle_valid, m_handle_qid, m_hv, m_hqid); end
         if (m_handle_valid) grants.push_back(int'(m_handle_qid));
      end
      checks++; if (grants.size() != 3) begin fails++; $display("FAIL rr_count: got %0d exp 3", grants.size()); end
      else begin
         checks++; if (grants[0] != 0 || grants[1] != 5 || grants[2] != 7) begin
            fails++; $display("FAIL rr_order: got %0d,%0d,%0d exp 0,5,7", grants[0], grants[1], grants[2]); end
      end
      deq_req = 1; deq_qid = 4'd5; tick(); deq_req = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (m_handle_valid) grants.push_back(int'(m_handle_qid));
      end
      checks++; if (grants.size() != 4 || grants[grants.size()-1] != 5) begin
         fails++; $display("FAIL rr_reissue: got n=%0d exp n=4 last=5", grants.size()); end
      m_handle_ready = 0;
   endtask

   task automatic test_empty_deq();
      deq_req = 1; deq_qid = 4'd4; tick(); deq_req = 0;
      checks++; if (m_deq_empty !== 1'b1 || m_deq_empty_qid !== 4'd4 || m_deq_valid !== 1'b0) begin
         fails++; $display("FAIL empty_deq: got e=%0b q=%0d v=%0b exp e=1 q=4 v=0", m_deq_empty, m_deq_empty_qid, m_deq_valid); end
      tick();
      checks++; if (m_deq_empty !== 1'b0) begin fails++; $display("FAIL empty_pulse: got %0b exp 0", m_deq_empty); end
   endtask

   task automatic test_same_cycle();
      logic [63:0] a;
      a = rdesc(8'd11);
      s_desc_valid = 1; s_desc_qid = 4'd1; s_desc = a; tick();
      s_desc = rdesc(8'd12); deq_req = 1; deq_qid = 4'd1; tick(); idle();
      checks++; if (m_deq_valid !== 1'b1 || m_deq_desc !== a) begin
         fails++; $display("FAIL same_cycle_head: got v=%0b d=%h exp v=1 d=%h", m_deq_valid, m_deq_desc, a); end
      stat_qid = 4'd1; tick();
      checks++; if (stat_occupancy !== 7'd1) begin fails++; $display("FAIL same_cycle_occ: got %0d exp 1", stat_occupancy); end
      s_desc_valid = 1; s_desc_qid = 4'd8; s_desc = rdesc(8'd13); deq_req = 1; deq_qid = 4'd8; tick(); idle();
      checks++; if (m_deq_empty !== 1'b1 || m_deq_empty_qid !== 4'd8 || m_deq_valid !== 1'b0) begin
         fails++; $display("FAIL empty_plus_enq: got e=%0b q=%0d v=%0b exp e=1 q=8 v=0", m_deq_empty, m_deq_empty_qid, m_deq_valid); end
      stat_qid = 4'd8; tick();
      checks++; if (stat_occupancy !== 7'd1) begin fails++; $display("FAIL empty_plus_enq_occ: got %0d exp 1", stat_occupancy); end
   endtask

   task automatic test_wrap_and_reset();
      longint dc0;
      free_ready = 1; stat_qid = 4'd6;
      for (int i = 0; i < 64; i++) begin
         s_desc_valid = 1; s_desc_qid = 4'd6; s_desc = rdesc(8'($urandom)); tick();
      end
      dc0 = m_dc;
      s_desc = rdesc(8'd1); tick(); idle();
      checks++; if (free_req !== 1'b1 || drop_count !== 32'(dc0 + 1)) begin
         fails++; $display("FAIL full_drop: got req=%0b drops=%0d exp req=1 drops=%0d", free_req, drop_count, dc0 + 1); end
      tick();
      checks++; if (stat_occupancy !== 7'd64) begin fails++; $display("FAIL full_occ: got %0d exp 64", stat_occupancy); end
      for (int i = 0; i < 300; i++) begin
         s_desc_valid = ($urandom_range(0, 99) < (i < 64 ? 0 : 55)); s_desc_qid = 4'd6; s_desc = rdesc(8'($urandom));
         deq_req = (i < 64) || ($urandom_range(0, 99) < 45); deq_qid = 4'd6;
         tick();
         checks++; if (m_deq_valid !== m_dv || (m_dv && m_deq_desc !== m_ddesc) || m_deq_empty !== m_de) begin
            fails++; $display("FAIL wrap_deq%0d: got v=%0b d=%h e=%0b exp v=%0b d=%h e=%0b", i, m_deq_valid, m_deq_desc, m_deq_empty, m_dv, m_ddesc, m_de); end
      end
      idle();
      for (int i = 0; i < 6; i++) begin
         s_desc_valid = 1; s_desc_qid = 4'(6 + 6 * (i % 2)); s_desc = rdesc(8'(i)); tick();
      end
      rst = 1; deq_req = 1; deq_qid = 4'd6; m_handle_ready = 1; tick(); rst = 0; idle(); m_handle_ready = 0;
      checks++; if (m_deq_valid !== 1'b0 || m_deq_empty !== 1'b0 || m_handle_valid !== 1'b0 || free_req !== 1'b0 || drop_count !== 32'd0) begin
         fails++; $display("FAIL mid_reset: got dv=%0b de=%0b hv=%0b fr=%0b drops=%0d exp all 0", m_deq_valid, m_deq_empty, m_handle_valid, free_req, drop_count); end
      for (int q = 0; q < NQ; q++) begin
         stat_qid = 4'(q); tick();
         checks++; if (stat_occupancy !== 7'd0 || m_handle_valid !== 1'b0 || m_deq_valid !== 1'b0) begin
            fails++; $display("FAIL post_reset_q%0d: got occ=%0d hv=%0b dv=%0b exp 0", q, stat_occupancy, m_handle_valid, m_deq_valid); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         s_desc_valid   = ($urandom_range(0, 99) < 60);
         s_desc_qid     = 4'($urandom_range(0, 5));
         s_desc         = rdesc(8'($urandom));
         deq_req        = ($urandom_range(0, 99) < 35);
         deq_qid        = 4'($urandom_range(0, 6));
         m_handle_ready = ($urandom_range(0, 99) < 50);
         free_ready     = ($urandom_range(0, 99) < 50);
         cfg_wr         = ($urandom_range(0, 99) < 4);
         cfg_qid        = 4'($urandom_range(0, 5));
         cfg_limit      = 7'($urandom_range(0, 100));
         stat_qid       = 4'($urandom_range(0, 6));
         tick();
         checks++; if (s_desc_ready !== !m_fr || free_req !== m_fr || (m_fr && free_addr !== m_fa) || drop_count !== 32'(m_dc)) begin
            fails++; $display("FAIL rnd_free%0d: got fr=%0b a=%h drops=%0d exp fr=%0b a=%h drops=%0d", i, free_req, free_addr, drop_count, m_fr, m_fa, m_dc); end
         checks++; if (m_handle_valid !== m_hv || (m_hv && (m_handle_qid !== 4'(m_hqid) || m_handle_prio !== m_hprio))) begin
            fails++; $display("FAIL rnd_handle%0d: got v=%0b q=%0d p=%0d exp v=%0b q=%0d p=%0d", i, m_handle_valid, m_handle_qid, m_handle_prio, m_hv, m_hqid, m_hprio); end
         checks++; if (m_deq_valid !== m_dv || (m_dv && m_deq_desc !== m_ddesc) || m_deq_empty !== m_de || (m_de && m_deq_empty_qid !== 4'(m_deqid))) begin
            fails++; $display("FAIL rnd_deq%0d: got v=%0b d=%h e=%0b q=%0d exp v=%0b d=%h e=%0b q=%0d", i, m_deq_valid, m_deq_desc, m_deq_empty, m_deq_empty_qid, m_dv, m_ddesc, m_de, m_deqid); end
         checks++; if (stat_occupancy !== 7'(m_stat)) begin
            fails++; $display("FAIL rnd_stat%0d: got %0d exp %0d", i, stat_occupancy, m_stat); end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_enqueue_handle();
      test_drop();
      test_round_robin();
      test_empty_deq();
      test_same_cycle();
      test_wrap_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
